// File: rtl/ccip_avmm_burst_splitter.sv
// Splits Avalon-MM bursts of 1..64 lines into naturally aligned 1/2/4-line sub-bursts
// so the downstream CCI-P bridge only sees legal burst shapes. Read data passes through.
module ccip_avmm_burst_splitter #(
  parameter int unsigned ADDR_WIDTH      = 48,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned IN_BURST_WIDTH  = 7,
  parameter int unsigned OUT_BURST_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [IN_BURST_WIDTH-1:0] avs_burstcount,
  input  logic [DATA_WIDTH-1:0]     avs_writedata,
  input  logic [DATA_WIDTH/8-1:0]   avs_byteenable,
  output logic                      avs_waitrequest,
  output logic [DATA_WIDTH-1:0]     avs_readdata,
  output logic                      avs_readdatavalid,
  output logic [ADDR_WIDTH-1:0]     avm_address,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [OUT_BURST_WIDTH-1:0] avm_burstcount,
  output logic [DATA_WIDTH-1:0]     avm_writedata,
  output logic [DATA_WIDTH/8-1:0]   avm_byteenable,
  input  logic                      avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]     avm_readdata,
  input  logic                      avm_readdatavalid
);

  localparam int unsigned LineW = ADDR_WIDTH - 6;

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e                    r_state, w_state_nxt;
  logic [LineW-1:0]          r_line, w_line_nxt;
  logic [IN_BURST_WIDTH-1:0] r_rem, w_rem_nxt;
  logic [IN_BURST_WIDTH-1:0] r_beat, w_beat_nxt;

  logic [LineW-1:0]          w_live_line;
  logic [IN_BURST_WIDTH-1:0] w_live_rem;
  logic [IN_BURST_WIDTH-1:0] w_size;
  logic                      w_unused_addr;

  function automatic logic [IN_BURST_WIDTH-1:0] f_size(input logic [1:0]                l,
                                                       input logic [IN_BURST_WIDTH-1:0] r);
    if (l == 2'b00 && r >= IN_BURST_WIDTH'(4)) begin
      return IN_BURST_WIDTH'(4);
    end else if (l[0] == 1'b0 && r >= IN_BURST_WIDTH'(2)) begin
      return IN_BURST_WIDTH'(2);
    end else begin
      return IN_BURST_WIDTH'(1);
    end
  endfunction

  assign w_live_line   = avs_address[ADDR_WIDTH-1:6];
  assign w_live_rem    = (avs_burstcount == '0) ? IN_BURST_WIDTH'(1) : avs_burstcount;
  assign w_unused_addr = ^avs_address[5:0];

  assign avs_readdata      = avm_readdata;
  assign avs_readdatavalid = avm_readdatavalid;
  assign avm_writedata     = avs_writedata;
  assign avm_byteenable    = avs_byteenable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_line  <= '0;
      r_rem   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_rem   <= w_rem_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_line_nxt      = r_line;
    w_rem_nxt       = r_rem;
    w_beat_nxt      = r_beat;
    w_size          = f_size(r_line[1:0], r_rem);
    avs_waitrequest = 1'b0;
    avm_read        = 1'b0;
    avm_write       = 1'b0;
    avm_address     = '0;
    avm_burstcount  = OUT_BURST_WIDTH'(1);

    unique case (r_state)
      StIdle: begin
        // Outputs stay quiet while reset is held, even if the master drives strobes.
        if (!reset) begin
          if (avs_read) begin
            w_line_nxt  = w_live_line;
            w_rem_nxt   = w_live_rem;
            w_state_nxt = StRd;
          end else if (avs_write) begin
            // First write beat goes out in the same cycle, sized from the live command.
            w_size          = f_size(w_live_line[1:0], w_live_rem);
            avm_write       = 1'b1;
            avm_address     = {w_live_line, 6'b0};
            avm_burstcount  = OUT_BURST_WIDTH'(w_size);
            avs_waitrequest = avm_waitrequest;
            if (!avm_waitrequest) begin
              if (w_size == IN_BURST_WIDTH'(1)) begin
                w_line_nxt = w_live_line + LineW'(1);
                w_rem_nxt  = w_live_rem - IN_BURST_WIDTH'(1);
                w_beat_nxt = '0;
              end else begin
                w_line_nxt = w_live_line;
                w_rem_nxt  = w_live_rem;
                w_beat_nxt = IN_BURST_WIDTH'(1);
              end
              if (w_live_rem != IN_BURST_WIDTH'(1)) begin
                w_state_nxt = StWr;
              end
            end
          end
        end
      end
      StRd: begin
        avm_read        = 1'b1;
        avm_address     = {r_line, 6'b0};
        avm_burstcount  = OUT_BURST_WIDTH'(w_size);
        avs_waitrequest = 1'b1;
        if (!avm_waitrequest) begin
          w_line_nxt = r_line + LineW'(w_size);
          w_rem_nxt  = r_rem - w_size;
          if (r_rem == w_size) begin
            w_state_nxt = StIdle;
          end
        end
      end
      StWr: begin
        avm_write       = avs_write;
        avm_address     = {r_line, 6'b0};
        avm_burstcount  = OUT_BURST_WIDTH'(w_size);
        avs_waitrequest = avm_waitrequest;
        if (avs_write && !avm_waitrequest) begin
          if (r_beat == w_size - IN_BURST_WIDTH'(1)) begin
            w_line_nxt = r_line + LineW'(w_size);
            w_rem_nxt  = r_rem - w_size;
            w_beat_nxt = '0;
            if (r_rem == w_size) begin
              w_state_nxt = StIdle;
            end
          end else begin
            w_beat_nxt = r_beat + IN_BURST_WIDTH'(1);
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ccip_avmm_burst_splitter.sv
// Directed bench for the burst splitter: a vector table of bursts with hand-computed
// sub-burst sequences, plus hand-written backpressure and reset sequences.
module tb_ccip_avmm_burst_splitter;

  typedef logic [511:0] w_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [47:0]  avs_address;
  logic         avs_read;
  logic         avs_write;
  logic [6:0]   avs_burstcount;
  logic [511:0] avs_writedata;
  logic [63:0]  avs_byteenable;
  logic         avs_waitrequest;
  logic [511:0] avs_readdata;
  logic         avs_readdatavalid;
  logic [47:0]  avm_address;
  logic         avm_read;
  logic         avm_write;
  logic [2:0]   avm_burstcount;
  logic [511:0] avm_writedata;
  logic [63:0]  avm_byteenable;
  logic         avm_waitrequest;
  logic [511:0] avm_readdata;
  logic         avm_readdatavalid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            name;
    bit               is_wr;
    logic [47:0]      addr;
    logic [6:0]       bc;
    int               n;
    logic [7:0][47:0] ea;
    logic [7:0][2:0]  eb;
  } vec_t;

  vec_t vecs[8];
  int   nvec = 0;

  ccip_avmm_burst_splitter dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_burstcount    (avs_burstcount),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_burstcount    (avm_burstcount),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input w_t act, input w_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input bit w, input logic [47:0] a, input logic [6:0] bc);
    vecs[nvec].name  = nm;
    vecs[nvec].is_wr = w;
    vecs[nvec].addr  = a;
    vecs[nvec].bc    = bc;
    vecs[nvec].n     = 0;
    vecs[nvec].ea    = '0;
    vecs[nvec].eb    = '0;
    nvec++;
  endtask

  task automatic exp_sub(input logic [47:0] a, input logic [2:0] b);
    vecs[nvec-1].ea[vecs[nvec-1].n] = a;
    vecs[nvec-1].eb[vecs[nvec-1].n] = b;
    vecs[nvec-1].n++;
  endtask

  function automatic w_t pat(input int k);
    return {16{32'hC0DE0000 + 32'(k)}};
  endfunction

  task automatic run_case(input vec_t v);
    avs_address    = v.addr;
    avs_burstcount = v.bc;
    if (!v.is_wr) begin
      avs_read = 1'b1;
      @(negedge clk);
      chk({v.name, " cmd_accept"}, w_t'(avs_waitrequest), w_t'(0));
      tick();
      avs_read = 1'b0;
      for (int k = 0; k < v.n; k++) begin
        @(negedge clk);
        chk($sformatf("%s sub%0d read", v.name, k), w_t'(avm_read), w_t'(1));
        chk($sformatf("%s sub%0d addr", v.name, k), w_t'(avm_address), w_t'(v.ea[k]));
        chk($sformatf("%s sub%0d bc", v.name, k), w_t'(avm_burstcount), w_t'(v.eb[k]));
        chk($sformatf("%s sub%0d stall", v.name, k), w_t'(avs_waitrequest), w_t'(1));
        tick();
      end
      @(negedge clk);
      chk({v.name, " idle_read"}, w_t'(avm_read), w_t'(0));
      chk({v.name, " idle_stall"}, w_t'(avs_waitrequest), w_t'(0));
      tick();
    end else begin
      for (int k = 0; k < v.n; k++) begin
        avs_write     = 1'b1;
        avs_writedata = pat(k);
        @(negedge clk);
        chk($sformatf("%s beat%0d write", v.name, k), w_t'(avm_write), w_t'(1));
        chk($sformatf("%s beat%0d addr", v.name, k), w_t'(avm_address), w_t'(v.ea[k]));
        chk($sformatf("%s beat%0d bc", v.name, k), w_t'(avm_burstcount), w_t'(v.eb[k]));
        chk($sformatf("%s beat%0d data", v.name, k), avm_writedata, pat(k));
        chk($sformatf("%s beat%0d stall", v.name, k), w_t'(avs_waitrequest), w_t'(0));
        tick();
      end
      avs_write = 1'b0;
      @(negedge clk);
      chk({v.name, " idle_write"}, w_t'(avm_write), w_t'(0));
      tick();
    end
  endtask

  initial begin
    vec_t v;
    int   beat;
    int   cyc;
    bit   wr_stall;

    add("rd_40_8", 1'b0, 48'h40, 7'd8);
    exp_sub(48'h40, 3'd1); exp_sub(48'h80, 3'd2); exp_sub(48'h100, 3'd4); exp_sub(48'h200, 3'd1);
    add("rd_1c0_0", 1'b0, 48'h1C0, 7'd0);
    exp_sub(48'h1C0, 3'd1);
    add("rd_0_4", 1'b0, 48'h0, 7'd4);
    exp_sub(48'h0, 3'd4);
    add("rd_140_5", 1'b0, 48'h140, 7'd5);
    exp_sub(48'h140, 3'd1); exp_sub(48'h180, 3'd2); exp_sub(48'h200, 3'd2);
    add("wr_0_4", 1'b1, 48'h0, 7'd4);
    exp_sub(48'h0, 3'd4); exp_sub(48'h0, 3'd4); exp_sub(48'h0, 3'd4); exp_sub(48'h0, 3'd4);
    add("wr_c0_3", 1'b1, 48'hC0, 7'd3);
    exp_sub(48'hC0, 3'd1); exp_sub(48'h100, 3'd2); exp_sub(48'h100, 3'd2);
    add("wr_40_1", 1'b1, 48'h40, 7'd1);
    exp_sub(48'h40, 3'd1);
    add("wr_80_2", 1'b1, 48'h80, 7'd2);
    exp_sub(48'h80, 3'd2); exp_sub(48'h80, 3'd2);

    reset             = 1'b1;
    avs_address       = 48'h1C0;
    avs_read          = 1'b0;
    avs_write         = 1'b1;
    avs_burstcount    = 7'd4;
    avs_writedata     = '0;
    avs_byteenable    = '1;
    avm_waitrequest   = 1'b1;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;

    // Reset state, with a write strobe driven to show outputs are held off.
    @(negedge clk);
    chk("rst avm_read", w_t'(avm_read), w_t'(0));
    chk("rst avm_write", w_t'(avm_write), w_t'(0));
    chk("rst avm_address", w_t'(avm_address), w_t'(0));
    chk("rst avm_burstcount", w_t'(avm_burstcount), w_t'(1));
    chk("rst avs_waitrequest", w_t'(avs_waitrequest), w_t'(0));
    avs_write       = 1'b0;
    avm_waitrequest = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < nvec; i++) begin
      run_case(vecs[i]);
    end

    // Read response passthrough.
    avm_readdata      = pat(77);
    avm_readdatavalid = 1'b1;
    #1;
    chk("rsp data", avs_readdata, pat(77));
    chk("rsp valid", w_t'(avs_readdatavalid), w_t'(1));
    avm_readdatavalid = 1'b0;
    tick();

    // Read with downstream stalls: command must hold steady until accepted.
    avs_address     = 48'h40;
    avs_burstcount  = 7'd2;
    avs_read        = 1'b1;
    avm_waitrequest = 1'b1;
    tick();
    avs_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) avm_waitrequest = 1'b0;
      @(negedge clk);
      chk($sformatf("bp hold%0d read", k), w_t'(avm_read), w_t'(1));
      chk($sformatf("bp hold%0d addr", k), w_t'(avm_address), w_t'(48'h40));
      chk($sformatf("bp hold%0d bc", k), w_t'(avm_burstcount), w_t'(1));
      tick();
    end
    @(negedge clk);
    chk("bp sub1 addr", w_t'(avm_address), w_t'(48'h80));
    chk("bp sub1 bc", w_t'(avm_burstcount), w_t'(1));
    tick();
    @(negedge clk);
    chk("bp idle read", w_t'(avm_read), w_t'(0));
    tick();

    // 64-line write with avm_waitrequest toggling every other cycle.
    avs_address    = 48'h0;
    avs_burstcount = 7'd64;
    beat           = 0;
    cyc            = 0;
    while (beat < 64 && cyc < 300) begin
      wr_stall        = (cyc % 2 == 0);
      avm_waitrequest = wr_stall;
      avs_write       = 1'b1;
      avs_writedata   = pat(beat);
      @(negedge clk);
      chk($sformatf("w64 c%0d write", cyc), w_t'(avm_write), w_t'(1));
      chk($sformatf("w64 c%0d addr", cyc), w_t'(avm_address), w_t'((beat / 4) * 256));
      chk($sformatf("w64 c%0d bc", cyc), w_t'(avm_burstcount), w_t'(4));
      chk($sformatf("w64 c%0d data", cyc), avm_writedata, pat(beat));
      chk($sformatf("w64 c%0d stall", cyc), w_t'(avs_waitrequest), w_t'(wr_stall));
      if (!wr_stall) beat++;
      tick();
      cyc++;
    end
    avs_write       = 1'b0;
    avm_waitrequest = 1'b0;
    chk("w64 cycles", w_t'(cyc), w_t'(128));
    @(negedge clk);
    chk("w64 idle write", w_t'(avm_write), w_t'(0));
    chk("w64 idle stall", w_t'(avs_waitrequest), w_t'(0));
    tick();

    // Reset mid-read after two sub-bursts are accepted.
    avs_address    = 48'h0;
    avs_burstcount = 7'd16;
    avs_read       = 1'b1;
    tick();
    avs_read = 1'b0;
    @(negedge clk);
    chk("rst_mid sub0 addr", w_t'(avm_address), w_t'(48'h0));
    tick();
    @(negedge clk);
    chk("rst_mid sub1 addr", w_t'(avm_address), w_t'(48'h100));
    chk("rst_mid sub1 bc", w_t'(avm_burstcount), w_t'(4));
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid read drop", w_t'(avm_read), w_t'(0));
    chk("rst_mid stall", w_t'(avs_waitrequest), w_t'(0));
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_mid after read", w_t'(avm_read), w_t'(0));
    tick();

    v.name  = "post_rst_rd_80_1";
    v.is_wr = 1'b0;
    v.addr  = 48'h80;
    v.bc    = 7'd1;
    v.n     = 1;
    v.ea    = '0;
    v.eb    = '0;
    v.ea[0] = 48'h80;
    v.eb[0] = 3'd1;
    run_case(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccip_avmm_burst_splitter.md
# ccip_avmm_burst_splitter

Upstream stage of the AVMM-to-CCI-P host bridge. It accepts Avalon-MM read and write bursts of 1 to 64 lines at any line-aligned address. It re-issues each burst downstream as a sequence of CCI-P-legal sub-bursts of 1, 2 or 4 lines, each naturally aligned to its own size. The downstream host bridge therefore only ever sees burstcount values 1, 2 or 4 on aligned addresses. Read response data passes straight through.

## Interface
Parameters:
- ADDR_WIDTH, 48, byte address width; bits [5:0] are ignored (line granularity).
- DATA_WIDTH, 512, data width, one cache line per beat.
- IN_BURST_WIDTH, 7, upstream burstcount width; maximum 64.
- OUT_BURST_WIDTH, 3, downstream burstcount width; values 1, 2 or 4 only.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  ADDR_WIDTH  upstream byte address.
- avs_read, avs_write  in  1  upstream command strobes.
- avs_burstcount  in  IN_BURST_WIDTH  upstream burst length in lines; 0 is treated as 1.
- avs_writedata  in  DATA_WIDTH  write beat data.
- avs_byteenable  in  DATA_WIDTH/8  forwarded unchanged.
- avs_waitrequest  out  1  upstream stall.
- avs_readdata  out  DATA_WIDTH  equals avm_readdata.
- avs_readdatavalid  out  1  equals avm_readdatavalid.
- avm_address  out  ADDR_WIDTH  sub-burst start address; bits [5:0] are 0.
- avm_read, avm_write  out  1  downstream strobes.
- avm_burstcount  out  OUT_BURST_WIDTH  sub-burst size.
- avm_writedata, avm_byteenable  out  forwarded from avs_writedata and avs_byteenable.
- avm_waitrequest  in  1  downstream stall.
- avm_readdata  in  DATA_WIDTH  read response data.
- avm_readdatavalid  in  1  read response valid.

## Operation
Sub-burst size rule, applied at line index L with R lines remaining:
- 4 if L[1:0]==0 and R>=4;
- else 2 if L[0]==0 and R>=2;
- else 1.

State machine:
- IDLE
  - On avs_read, capture L=avs_address[47:6] and R=burstcount (0 is taken as 1); go RD.
  - On avs_write, forward the beat combinationally, using the size rule on the live address and count.
  - When that beat is accepted and the burst is longer than 1, go WR.
  - avs_read and avs_write are never asserted together; if they are, the read wins.
- RD
  - avm_read=1, avm_address={L,6'b0}, avm_burstcount=size(L,R).
  - Accepted means avm_read & ~avm_waitrequest. On acceptance: L+=size, R-=size.
  - When R==size at acceptance, go IDLE.
- WR
  - avm_write=avs_write. avm_address and avm_burstcount are held at the current sub-burst values on every beat of that sub-burst.
  - A beat counter B counts accepted beats within the sub-burst.
  - When B==size-1 on an accepted beat: L+=size, R-=size, B=0.
  - When R==size at that point, go IDLE.

Stall and passthrough:
- avs_waitrequest is 1 in RD.
- avs_waitrequest equals avm_waitrequest in WR, and in IDLE while avs_write=1.
- avs_waitrequest is 0 in IDLE otherwise.
- avs_read is ignored in WR.
- Read responses are a combinational passthrough. Response ordering is the responsibility of downstream logic.

Arithmetic:
- L is ADDR_WIDTH-6 bits and wraps modulo 2^(ADDR_WIDTH-6).
- R and B are IN_BURST_WIDTH bits. R never underflows, because size<=R by construction.

## Timing
- Reset values: state=IDLE, L=R=B=0, avm_read=0, avm_write=0, avm_address=0, avm_burstcount=1. avs_waitrequest=0 while in reset.
- Reads:
  - The command is accepted in 1 cycle.
  - The first avm_read appears the following cycle.
  - One sub-burst is issued per cycle without backpressure.
  - A burst of N sub-bursts frees upstream N+1 cycles after acceptance.
- Writes: zero-cycle forwarding, with one beat per cycle throughput.
- avm_waitrequest held high: all avm_* outputs stay stable until acceptance.
- Reset asserted mid-burst: the block returns to IDLE immediately and the remainder of the burst is dropped.

## Test plan
- Read 0x40, burstcount 8 -> four avm_read sub-bursts: (0x40, 1), (0x80, 2), (0x100, 4), (0x200, 1) on consecutive cycles; then IDLE.
- Write 0x0, burstcount 4 -> 4 beats, each with avm_address 0x0 and avm_burstcount 4; data matches in order.
- Write 0xC0, burstcount 3 -> beat 1 at (0xC0, 1); beats 2 and 3 at (0x100, 2).
- Write 0x0, burstcount 64, with avm_waitrequest toggling every other cycle -> 16 sub-bursts of 4 at 0x0, 0x100, and so on up to 0xF00. No beat is lost or duplicated, and avs_waitrequest mirrors avm_waitrequest.
- Read 0x0, burstcount 16; reset asserted after the 2nd acceptance -> avm_read drops in the same cycle and the state is IDLE. A following read of 0x80, burstcount 1 yields a single (0x80, 1).
- Read with burstcount 0 at 0x1C0 -> a single sub-burst (0x1C0, 1).
